// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - bus bundle between CPU Memory stage, DMA loader, arbiter and data memory
//
// Purpose: groups every requester and memory signal of the data memory arbiter.
// Modports:
//   slave  - the arbiter: takes CPU/DMA requests and memReadData, drives grants,
//            read data, stall and the memory write/address/data lines.
//   master - the surroundings: CPU stage, DMA loader and the memory instance.
// Ports summary:
//   CPU : cpuReq, cpuWrite, cpuAddress, cpuWriteData -> cpuReadData, cpuStall
//   DMA : dmaReq, dmaWrite, dmaAddress, dmaBurstLen, dmaWriteData
//         -> dmaGrant, dmaBeat, dmaReadData, dmaValid, dmaDone
//   MEM : memWriteEnable, memAddress, memWriteData -> memReadData (async read)
interface data_mem_arbiter_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_BURST     = 16
);
    localparam int W     = DATA_WIDTH * VECTOR_SIZE;
    localparam int LEN_W = $clog2(MAX_BURST + 1);

    logic                     cpuReq;
    logic                     cpuWrite;
    logic [ADDRESS_WIDTH-1:0] cpuAddress;
    logic [W-1:0]             cpuWriteData;
    logic [W-1:0]             cpuReadData;
    logic                     cpuStall;

    logic                     dmaReq;
    logic                     dmaWrite;
    logic [ADDRESS_WIDTH-1:0] dmaAddress;
    logic [LEN_W-1:0]         dmaBurstLen;
    logic [W-1:0]             dmaWriteData;
    logic                     dmaGrant;
    logic                     dmaBeat;
    logic [W-1:0]             dmaReadData;
    logic                     dmaValid;
    logic                     dmaDone;

    logic                     memWriteEnable;
    logic [ADDRESS_WIDTH-1:0] memAddress;
    logic [W-1:0]             memWriteData;
    logic [W-1:0]             memReadData;

    modport slave (
        input  cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        output cpuReadData, cpuStall,
        input  dmaReq, dmaWrite, dmaAddress, dmaBurstLen, dmaWriteData,
        output dmaGrant, dmaBeat, dmaReadData, dmaValid, dmaDone,
        output memWriteEnable, memAddress, memWriteData,
        input  memReadData
    );

    modport master (
        output cpuReq, cpuWrite, cpuAddress, cpuWriteData,
        input  cpuReadData, cpuStall,
        output dmaReq, dmaWrite, dmaAddress, dmaBurstLen, dmaWriteData,
        input  dmaGrant, dmaBeat, dmaReadData, dmaValid, dmaDone,
        input  memWriteEnable, memAddress, memWriteData,
        output memReadData
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - CPU/DMA arbiter for the shared vector data memory
//
// Purpose: one grantee per cycle on the data memory. CPU accesses complete in the
// cycle they are granted; DMA moves bursts of whole vectors. Starvation counters
// bound the wait of either side to STARVE_LIMIT beats of the other.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous, active-low
//   bus   - data_mem_arbiter_if.slave (CPU, DMA and memory signals)
module data_mem_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int VECTOR_SIZE   = 6,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MAX_BURST     = 16,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_arbiter_if.slave    bus
);
    localparam int W      = DATA_WIDTH * VECTOR_SIZE;
    localparam int LEN_W  = $clog2(MAX_BURST + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                   state, nextState;
    logic [ADDRESS_WIDTH-1:0] burstAddr;
    logic                     burstWrite;
    logic [LEN_W-1:0]         beatsLeft;
    logic [WAIT_W-1:0]        cpuWait, dmaWait;
    logic [W-1:0]             dmaReadDataReg;
    logic                     dmaValidReg, dmaDoneReg;

    logic                     cpuGrant, dmaGrantNow, beat, lastBeat;
    logic [ADDRESS_WIDTH-1:0] beatAddr;
    logic                     beatWrite;
    logic [LEN_W-1:0]         effLen;

    // Zero-length bursts still move one word; oversize bursts are clamped.
    always_comb begin
        effLen = bus.dmaBurstLen;
        if (bus.dmaBurstLen == '0)
            effLen = LEN_W'(1);
        else if (bus.dmaBurstLen > LEN_W'(MAX_BURST))
            effLen = LEN_W'(MAX_BURST);
    end

    always_comb begin
        nextState   = state;
        cpuGrant    = 1'b0;
        dmaGrantNow = 1'b0;
        beat        = 1'b0;
        lastBeat    = 1'b0;
        beatAddr    = burstAddr;
        beatWrite   = burstWrite;
        case (state)
            IDLE: begin
                // CPU has priority unless the DMA has already waited its limit.
                if (bus.dmaReq && (!bus.cpuReq || dmaWait == WAIT_MAX)) begin
                    dmaGrantNow = 1'b1;
                    beat        = 1'b1;
                    beatAddr    = bus.dmaAddress;
                    beatWrite   = bus.dmaWrite;
                    lastBeat    = (effLen == LEN_W'(1));
                    if (!lastBeat)
                        nextState = BURST;
                end else if (bus.cpuReq) begin
                    cpuGrant = 1'b1;
                end
            end
            BURST: begin
                // Inside a burst the DMA owns the memory except for one
                // preempting CPU slot after STARVE_LIMIT stalled beats.
                if (bus.cpuReq && cpuWait == WAIT_MAX) begin
                    cpuGrant = 1'b1;
                end else begin
                    beat     = 1'b1;
                    lastBeat = (beatsLeft == LEN_W'(1));
                    if (lastBeat)
                        nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.memWriteEnable = 1'b0;
        bus.memAddress     = '0;
        bus.memWriteData   = '0;
        if (cpuGrant) begin
            bus.memWriteEnable = bus.cpuWrite;
            bus.memAddress     = bus.cpuAddress;
            bus.memWriteData   = bus.cpuWriteData;
        end else if (beat) begin
            bus.memWriteEnable = beatWrite;
            bus.memAddress     = beatAddr;
            bus.memWriteData   = bus.dmaWriteData;
        end
    end

    assign bus.cpuReadData = cpuGrant ? bus.memReadData : '0;
    assign bus.cpuStall    = bus.cpuReq & ~cpuGrant;
    assign bus.dmaGrant    = dmaGrantNow;
    assign bus.dmaBeat     = beat;
    assign bus.dmaReadData = dmaReadDataReg;
    assign bus.dmaValid    = dmaValidReg;
    assign bus.dmaDone     = dmaDoneReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            burstAddr      <= '0;
            burstWrite     <= 1'b0;
            beatsLeft      <= '0;
            cpuWait        <= '0;
            dmaWait        <= '0;
            dmaReadDataReg <= '0;
            dmaValidReg    <= 1'b0;
            dmaDoneReg     <= 1'b0;
        end else begin
            state <= nextState;

            if (dmaGrantNow) begin
                burstAddr  <= bus.dmaAddress + ADDRESS_WIDTH'(1);
                burstWrite <= bus.dmaWrite;
                beatsLeft  <= effLen - LEN_W'(1);
            end else if (beat) begin
                burstAddr <= burstAddr + ADDRESS_WIDTH'(1);
                beatsLeft <= beatsLeft - LEN_W'(1);
            end

            dmaValidReg <= beat && !beatWrite;
            if (beat && !beatWrite)
                dmaReadDataReg <= bus.memReadData;
            dmaDoneReg <= lastBeat;

            // cpuWait counts DMA beats the CPU sat through, grant beat included.
            if (!bus.cpuReq)
                cpuWait <= '0;
            else if (state == BURST && cpuGrant)
                cpuWait <= '0;
            else if (beat && cpuWait != WAIT_MAX)
                cpuWait <= cpuWait + WAIT_W'(1);

            // dmaWait counts CPU wins while a burst request is pending.
            if (!bus.dmaReq || dmaGrantNow)
                dmaWait <= '0;
            else if (state == IDLE && cpuGrant && dmaWait != WAIT_MAX)
                dmaWait <= dmaWait + WAIT_W'(1);
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
    localparam int K_GRANT = 0;
    localparam int K_BEAT  = 1;
    localparam int K_CPU   = 2;
    localparam int K_VALID = 3;
    localparam int K_DONE  = 4;

    typedef struct {
        int          cyc;
        int          kind;
        logic [7:0]  addr;
        logic        we;
        logic [47:0] data;
    } ev_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];
    logic [47:0] mem [256];

    data_mem_arbiter_if bus ();

    data_mem_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: asynchronous read, synchronous write.
    assign bus.memReadData  = mem[bus.memAddress];
    assign bus.dmaWriteData = {8'hAB, 32'h0, bus.memAddress};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {8'h5A, 32'h0, 8'(i)};
        mem[8'h10] = 48'h0A0B0C0D0E0F;
        forever begin
            @(posedge clock);
            if (bus.memWriteEnable) mem[bus.memAddress] <= bus.memWriteData;
        end
    end

    task automatic push(input int c, input int k, input logic [7:0] a, input logic w, input logic [47:0] d);
        ev_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.we = w; e.data = d;
        q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [7:0] a, input logic w, input logic [47:0] d);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL event: got cyc=%0d kind=%0d addr=%h we=%b data=%h, expected none", cyc, k, a, w, d);
        end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.addr != a || e.we != w || e.data != d) begin
                bad++;
                $display("FAIL event: got cyc=%0d kind=%0d addr=%h we=%b data=%h, expected cyc=%0d kind=%0d addr=%h we=%b data=%h",
                         cyc, k, a, w, d, e.cyc, e.kind, e.addr, e.we, e.data);
            end
        end
    endtask

    // Monitor: turns every observable DUT response into an event in a fixed order.
    always @(negedge clock) begin
        if (bus.dmaGrant) observe(K_GRANT, 8'h0, 1'b0, 48'h0);
        if (bus.dmaBeat)
            observe(K_BEAT, bus.memAddress, bus.memWriteEnable, bus.memWriteEnable ? bus.memWriteData : 48'h0);
        if (bus.cpuReq && !bus.cpuStall)
            observe(K_CPU, bus.memAddress, bus.memWriteEnable, bus.cpuWrite ? bus.memWriteData : bus.cpuReadData);
        if (bus.dmaValid) observe(K_VALID, 8'h0, 1'b0, bus.dmaReadData);
        if (bus.dmaDone)  observe(K_DONE, 8'h0, 1'b0, 48'h0);
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int c;
        reset = 0;
        bus.cpuReq = 0; bus.cpuWrite = 0; bus.cpuAddress = 0; bus.cpuWriteData = 0;
        bus.dmaReq = 0; bus.dmaWrite = 0; bus.dmaAddress = 0; bus.dmaBurstLen = 0;
        #2;
        check("rst_dmaValid", 48'(bus.dmaValid), 48'h0);
        check("rst_dmaDone", 48'(bus.dmaDone), 48'h0);
        check("rst_dmaGrant", 48'(bus.dmaGrant), 48'h0);
        check("rst_dmaReadData", bus.dmaReadData, 48'h0);
        check("rst_memAddress", 48'(bus.memAddress), 48'h0);
        check("rst_memWriteEnable", 48'(bus.memWriteEnable), 48'h0);
        tick(); tick();
        reset = 1;
        tick();

        // Uncontended CPU load and store.
        bus.cpuReq = 1; bus.cpuWrite = 0; bus.cpuAddress = 8'h10;
        #1;
        check("cpu_stall", 48'(bus.cpuStall), 48'h0);
        check("cpu_memAddress", 48'(bus.memAddress), 48'h10);
        check("cpu_readData", bus.cpuReadData, 48'h0A0B0C0D0E0F);
        push(cyc, K_CPU, 8'h10, 1'b0, 48'h0A0B0C0D0E0F);
        tick();
        bus.cpuWrite = 1; bus.cpuAddress = 8'h20; bus.cpuWriteData = 48'h123456789ABC;
        push(cyc, K_CPU, 8'h20, 1'b1, 48'h123456789ABC);
        tick();
        bus.cpuReq = 0; bus.cpuWrite = 0;
        tick();

        // DMA read burst wrapping 0xFF -> 0x00.
        c = cyc;
        bus.dmaReq = 1; bus.dmaWrite = 0; bus.dmaAddress = 8'hFE; bus.dmaBurstLen = 5'd3;
        push(c, K_GRANT, 8'h0, 1'b0, 48'h0);
        push(c, K_BEAT, 8'hFE, 1'b0, 48'h0);
        push(c + 1, K_BEAT, 8'hFF, 1'b0, 48'h0);
        push(c + 1, K_VALID, 8'h0, 1'b0, 48'h5A00000000FE);
        push(c + 2, K_BEAT, 8'h00, 1'b0, 48'h0);
        push(c + 2, K_VALID, 8'h0, 1'b0, 48'h5A00000000FF);
        push(c + 3, K_VALID, 8'h0, 1'b0, 48'h5A0000000000);
        push(c + 3, K_DONE, 8'h0, 1'b0, 48'h0);
        tick();
        bus.dmaReq = 0;
        repeat (4) tick();

        // DMA starvation then CPU starvation inside a 10-beat write burst.
        c = cyc;
        bus.cpuReq = 1; bus.cpuWrite = 0; bus.cpuAddress = 8'h20;
        bus.dmaReq = 1; bus.dmaWrite = 1; bus.dmaAddress = 8'h40; bus.dmaBurstLen = 5'd10;
        for (int k = 0; k < 4; k++) push(c + k, K_CPU, 8'h20, 1'b0, 48'h123456789ABC);
        push(c + 4, K_GRANT, 8'h0, 1'b0, 48'h0);
        for (int k = 0; k < 4; k++) push(c + 4 + k, K_BEAT, 8'h40 + 8'(k), 1'b1, {8'hAB, 32'h0, 8'h40 + 8'(k)});
        push(c + 8, K_CPU, 8'h20, 1'b0, 48'h123456789ABC);
        for (int k = 0; k < 4; k++) push(c + 9 + k, K_BEAT, 8'h44 + 8'(k), 1'b1, {8'hAB, 32'h0, 8'h44 + 8'(k)});
        push(c + 13, K_CPU, 8'h20, 1'b0, 48'h123456789ABC);
        push(c + 14, K_BEAT, 8'h48, 1'b1, 48'hAB0000000048);
        push(c + 15, K_BEAT, 8'h49, 1'b1, 48'hAB0000000049);
        push(c + 16, K_CPU, 8'h20, 1'b0, 48'h123456789ABC);
        push(c + 16, K_DONE, 8'h0, 1'b0, 48'h0);
        for (int k = 0; k < 4; k++) begin
            #1 check("starve_cpu_stall", 48'(bus.cpuStall), 48'h0);
            tick();
        end
        #1;
        check("starve_dma_grant", 48'(bus.dmaGrant), 48'h1);
        check("starve_grant_stall", 48'(bus.cpuStall), 48'h1);
        tick();
        bus.dmaReq = 0;
        for (int k = 5; k <= 16; k++) begin
            #1 check("burst_cpu_stall", 48'(bus.cpuStall), (k == 8 || k == 13 || k == 16) ? 48'h0 : 48'h1);
            tick();
        end
        bus.cpuReq = 0;
        tick(); tick();
        check("mem_write_45", mem[8'h45], 48'hAB0000000045);
        check("mem_write_49", mem[8'h49], 48'hAB0000000049);

        // Zero length behaves as a single beat.
        c = cyc;
        bus.dmaReq = 1; bus.dmaWrite = 0; bus.dmaAddress = 8'h30; bus.dmaBurstLen = 5'd0;
        push(c, K_GRANT, 8'h0, 1'b0, 48'h0);
        push(c, K_BEAT, 8'h30, 1'b0, 48'h0);
        push(c + 1, K_VALID, 8'h0, 1'b0, 48'h5A0000000030);
        push(c + 1, K_DONE, 8'h0, 1'b0, 48'h0);
        tick();
        bus.dmaReq = 0;
        repeat (3) tick();

        // Oversize length is clamped to 16 beats.
        c = cyc;
        bus.dmaReq = 1; bus.dmaWrite = 0; bus.dmaAddress = 8'h50; bus.dmaBurstLen = 5'd20;
        push(c, K_GRANT, 8'h0, 1'b0, 48'h0);
        for (int k = 0; k < 16; k++) begin
            push(c + k, K_BEAT, 8'h50 + 8'(k), 1'b0, 48'h0);
            if (k > 0) push(c + k, K_VALID, 8'h0, 1'b0, {8'h5A, 32'h0, 8'h4F + 8'(k)});
        end
        push(c + 16, K_VALID, 8'h0, 1'b0, 48'h5A000000005F);
        push(c + 16, K_DONE, 8'h0, 1'b0, 48'h0);
        tick();
        bus.dmaReq = 0;
        repeat (18) tick();

        // Reset in the middle of an 8-beat read burst.
        c = cyc;
        bus.dmaReq = 1; bus.dmaWrite = 0; bus.dmaAddress = 8'h60; bus.dmaBurstLen = 5'd8;
        push(c, K_GRANT, 8'h0, 1'b0, 48'h0);
        push(c, K_BEAT, 8'h60, 1'b0, 48'h0);
        push(c + 1, K_BEAT, 8'h61, 1'b0, 48'h0);
        push(c + 1, K_VALID, 8'h0, 1'b0, 48'h5A0000000060);
        tick();
        bus.dmaReq = 0;
        tick();
        reset = 0;
        #1;
        check("mid_rst_dmaBeat", 48'(bus.dmaBeat), 48'h0);
        check("mid_rst_dmaValid", 48'(bus.dmaValid), 48'h0);
        check("mid_rst_dmaReadData", bus.dmaReadData, 48'h0);
        check("mid_rst_dmaDone", 48'(bus.dmaDone), 48'h0);
        check("mid_rst_memAddress", 48'(bus.memAddress), 48'h0);
        check("mid_rst_memWriteEnable", 48'(bus.memWriteEnable), 48'h0);
        tick(); tick();
        reset = 1;
        bus.cpuReq = 1; bus.cpuWrite = 0; bus.cpuAddress = 8'h10;
        #1;
        check("post_rst_cpu_stall", 48'(bus.cpuStall), 48'h0);
        check("post_rst_cpu_data", bus.cpuReadData, 48'h0A0B0C0D0E0F);
        push(cyc, K_CPU, 8'h10, 1'b0, 48'h0A0B0C0D0E0F);
        tick();
        bus.cpuReq = 0;
        repeat (12) tick();
        check("scoreboard_drained", 48'(q.size()), 48'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single vector-wide data memory between the CPU Memory stage (port C) and a DMA/host loader (port D) that moves whole vectors in bursts.
- Sits between the pipeline's Memory stage and the data memory instance.
- Drives a combinational stall request into the hazards logic when the CPU loses arbitration.
- Guarantees bounded wait for both requesters through starvation counters.

Parameters:
- DATA_WIDTH, 8, element width.
- VECTOR_SIZE, 6, elements per memory word; the word is DATA_WIDTH*VECTOR_SIZE bits (W).
- ADDRESS_WIDTH, 8, memory address width.
- MAX_BURST, 16, maximum beats per DMA burst.
- STARVE_LIMIT, 4, maximum consecutive beats one port may hold the memory while the other waits.

Ports:
- clock  in  1  single clock; all state is on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- cpuReq  in  1  CPU Memory stage needs memory this cycle.
- cpuWrite  in  1  1 = store, 0 = load.
- cpuAddress  in  ADDRESS_WIDTH  CPU access address.
- cpuWriteData  in  W  store data.
- cpuReadData  out  W  load data; valid in the same cycle the CPU is granted.
- cpuStall  out  1  combinational; equals cpuReq AND NOT cpuGrant.
- dmaReq  in  1  DMA burst request; held until dmaGrant.
- dmaWrite  in  1  burst direction, sampled at grant.
- dmaAddress  in  ADDRESS_WIDTH  burst start address, sampled at grant.
- dmaBurstLen  in  clog2(MAX_BURST+1)  number of beats, sampled at grant.
- dmaWriteData  in  W  write word; sampled on each dmaBeat cycle.
- dmaGrant  out  1  one-cycle pulse; burst accepted and first beat issued.
- dmaBeat  out  1  combinational; a DMA beat uses the memory this cycle.
- dmaReadData  out  W  registered read data.
- dmaValid  out  1  registered; dmaReadData valid, one cycle after a read beat.
- dmaDone  out  1  registered pulse, one cycle after the last beat.
- memWriteEnable  out  1  to memory.
- memAddress  out  ADDRESS_WIDTH  to memory; shared read/write address.
- memWriteData  out  W  to memory.
- memReadData  in  W  from memory; asynchronous read.

Behaviour:
- States:
  - IDLE: no burst in progress.
  - BURST: registers burstAddr, burstWrite and beatsLeft (beats remaining) are held.
- Exactly one grantee per cycle, or none.
- Memory outputs are a combinational mux of the grantee's signals. With no grantee: memWriteEnable = 0, memAddress = 0, memWriteData = 0.
- IDLE arbitration:
  - DMA wins if dmaReq and (NOT cpuReq or dmaWait == STARVE_LIMIT). Otherwise CPU wins if cpuReq.
  - On a DMA win: dmaGrant = 1, the first beat is issued this cycle at dmaAddress, and the next state is BURST unless the effective length is 1.
  - Effective length: dmaBurstLen = 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST.
  - dmaWait increments on each CPU grant while dmaReq = 1. It clears on a DMA grant or when dmaReq = 0.
- BURST arbitration:
  - CPU wins if cpuReq and cpuWait == STARVE_LIMIT; that preempted beat clears cpuWait.
  - Otherwise a DMA beat issues at burstAddr. burstAddr increments modulo 2^ADDRESS_WIDTH (wrap 0xFF -> 0x00) and beatsLeft decrements.
  - cpuWait increments on each DMA beat while cpuReq = 1. It clears when cpuReq = 0.
  - The last beat (beatsLeft == 1) returns the FSM to IDLE.
  - dmaReq is ignored while in BURST.
- DMA data path:
  - Read beat: the next cycle has dmaValid = 1 and dmaReadData = that beat's memReadData.
  - Write beat: memWriteData = dmaWriteData and memWriteEnable = burstWrite (dmaWrite on the grant cycle).
  - dmaDone = 1 exactly one cycle after the last beat, coincident with the last dmaValid for a read burst.
- CPU path:
  - On a CPU grant, cpuReadData = memReadData. It is 0 when the CPU is not granted.
  - memWriteEnable = cpuWrite on a CPU grant.
- Latency: CPU has zero added latency when uncontended. DMA read data arrives 1 cycle after the beat.
- Simultaneous first requests in IDLE with both wait counters 0: CPU wins.
- Reset, including mid-burst:
  - Immediate return to IDLE with all counters 0.
  - dmaGrant, dmaValid, dmaDone and dmaReadData = 0.
  - The burst is abandoned with no dmaDone; combinational outputs follow.

Test Plan:
- Uncontended CPU: load at 0x10 with memory[0x10] = 0x0A0B0C0D0E0F -> cpuStall = 0, memAddress = 0x10, cpuReadData = 0x0A0B0C0D0E0F in the same cycle.
- DMA read burst: len 3 from 0xFE -> beats at 0xFE, 0xFF, 0x00; dmaValid on cycles 1–3 after grant; dmaDone on cycle 3 after grant.
- CPU starvation: 10-beat DMA write with cpuReq held high from beat 1 -> DMA beats 1–4, CPU beat, DMA beats 5–8, CPU beat, DMA beats 9–10. cpuStall is low only on the 2 CPU beats; dmaDone comes after 12 cycles.
- DMA starvation: cpuReq held high, dmaReq asserted -> CPU granted for 4 cycles, then dmaGrant on the 5th cycle with cpuStall = 1 that cycle.
- Length edge cases: dmaBurstLen = 0 -> exactly 1 beat; dmaBurstLen = 20 -> exactly 16 beats.
- Reset mid-burst: assert reset low after 2 beats of an 8-beat read -> outputs 0 immediately, no dmaDone. After release, a CPU request is granted in the same cycle.
